// File: rtl/demux_pkg.sv
// Shared constants and types for the stream demultiplexer.
// Holds the legal parameter ranges, the error counter width and the transfer classification.
package demux_pkg;

    localparam int ERR_W      = 8;
    localparam int N_CH_MIN   = 2;
    localparam int N_CH_MAX   = 16;
    localparam int DATA_W_MIN = 1;
    localparam int DATA_W_MAX = 64;

    typedef enum logic [1:0] {
        XFER_NONE,
        XFER_UNICAST,
        XFER_BCAST,
        XFER_BADSEL
    } xfer_kind_e;

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel entry: a single valid/data register with load and drain control.
// A load wins over a drain, so a channel can stream one word per cycle.
module demux_chan_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);

    logic drain;

    assign drain = valid & ready;
    assign free  = ~valid | drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes a valid/ready input stream to one of N_CH registered output channels, or to all of them.
// Words addressed to a non-existent channel are accepted, dropped and counted in err_cnt.
module stream_demux
    import demux_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [ERR_W-1:0]       err_cnt
);

    logic [N_CH-1:0] free;
    logic [N_CH-1:0] load;
    logic            sel_ok;
    logic            uni_free;
    xfer_kind_e      kind;

    // When N_CH fills the select range every code is a real channel.
    if (N_CH == (1 << SEL_W)) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_partial
        assign sel_ok = (32'(in_sel) < N_CH);
    end

    always_comb begin
        uni_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (32'(in_sel) == k) begin
                uni_free = free[k];
            end
        end

        if (in_bcast) begin
            in_ready = &free;
        end else if (!sel_ok) begin
            in_ready = 1'b1;
        end else begin
            in_ready = uni_free;
        end

        kind = XFER_NONE;
        if (in_valid && in_ready) begin
            if (in_bcast) begin
                kind = XFER_BCAST;
            end else if (!sel_ok) begin
                kind = XFER_BADSEL;
            end else begin
                kind = XFER_UNICAST;
            end
        end

        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = (kind == XFER_BCAST) || ((kind == XFER_UNICAST) && (32'(in_sel) == k));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        demux_chan_reg #(
            .DATA_W(DATA_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .ready    (out_ready[k]),
            .load_data(in_data),
            .valid    (out_valid[k]),
            .data     (out_data[k*DATA_W +: DATA_W]),
            .free     (free[k])
        );
    end

    // Dropped words saturate the counter rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (kind == XFER_BADSEL && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of output channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 8, payload width in bits (1..64).
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(N_CH)), select width.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have in_valid  input  1  upstream word present.
REQ-007 SHALL have in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have in_data  input  DATA_W  payload.
REQ-009 SHALL have in_sel  input  SEL_W  destination channel.
REQ-010 SHALL have in_bcast  input  1  1 = deliver to all channels, in_sel ignored.
REQ-011 SHALL have out_valid  output  N_CH  per-channel word present.
REQ-012 SHALL have out_ready  input  N_CH  per-channel downstream accept.
REQ-013 SHALL have out_data  output  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have err_cnt  output  8  count of discarded invalid-select words.

Function
REQ-015 SHALL treat a transfer as in_valid & in_ready, and a drain of channel k as out_valid[k] & out_ready[k].
REQ-016 SHALL hold one registered entry per channel; channel k is "free" when out_valid[k]=0 or it drains this cycle.
REQ-017 SHALL drive in_ready combinationally: unicast = free[in_sel]; broadcast = AND of all free; invalid select (in_sel >= N_CH, in_bcast=0) = 1.
REQ-018 SHALL, on a unicast transfer, load in_data into channel in_sel and set its out_valid on the next edge (latency 1 cycle).
REQ-019 SHALL, on a broadcast transfer, load in_data into every channel and set all out_valid on the same edge.
REQ-020 SHALL, on an invalid-select transfer, load no channel and increment err_cnt, saturating at 255.
REQ-021 SHALL clear out_valid[k] after a drain with no simultaneous load into k.
REQ-022 SHALL, on simultaneous drain and load of channel k, keep out_valid[k]=1 and present the new word, sustaining one word per cycle per channel.
REQ-023 SHALL hold out_data[k] unchanged whenever channel k is not loaded.
REQ-024 SHALL never overwrite a valid, non-draining channel, and never drop or duplicate an accepted valid-select word.
REQ-025 SHALL let in_valid/in_data/in_sel/in_bcast change freely while in_ready=0, with no effect on state.

Reset
REQ-026 SHALL, while rst=1, set out_valid=0, out_data=0 and err_cnt=0 on the next edge, overriding any concurrent transfer or drain.
REQ-027 SHALL discard held words when rst is asserted mid-operation; in_ready SHALL be 1 in the first cycle after reset for any select.

Structure
REQ-028 SHALL place the err_cnt width (8) and the N_CH/DATA_W legal-range constants in shared package demux_pkg.
REQ-029 SHALL implement each channel entry as one instance of sub-module demux_chan_reg (valid/data register with load and drain inputs), generated N_CH times.

Verification
REQ-030 Bench SHALL run: N_CH=8, DATA_W=8, out_ready all 1, unicast 0xA5 to sel 3 -> next cycle out_valid=8'b0000_1000, channel 3 data 0xA5, then out_valid=0.
REQ-031 Bench SHALL run: out_ready[2]=0, send 0x11 then 0x22 to sel 2 -> second word stalls (in_ready=0), channel 2 holds 0x11; raise out_ready[2] -> 0x22 appears the next cycle.
REQ-032 Bench SHALL run: out_ready[5]=0 with channel 5 full, broadcast 0x3C -> in_ready=0; release out_ready[5] -> same cycle in_ready=1, next cycle all 8 channels hold 0x3C.
REQ-033 Bench SHALL run: N_CH=6, in_sel=7 for 300 valid cycles -> no out_valid change, in_ready=1 throughout, err_cnt saturates at 255.
REQ-034 Bench SHALL run: continuous unicast to sel 0 with out_ready[0]=1, 10 words -> 10 consecutive cycles of out_valid[0]=1 carrying the words in order.
REQ-035 Bench SHALL run: assert rst for 1 cycle with channels 1 and 4 full and a transfer pending -> next cycle out_valid=0, out_data=0, err_cnt=0, in_ready=1.
